// File: rtl/vsync_module_2018fall_template.sv
// ---------------------------------------------------------------------------
// vsync_module_2018fall_template
// Vertical-sync generator for the VGA Pong display path. Counts line-end
// rising edges from the hsync block and walks a run-time programmable frame:
// sync pulse, back porch, active video, front porch.
//
// Ports:
//   clock        system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   LineEnd      line-end strobe/level from hsync block
//   SynchPulse   vsync pulse length in lines (S)
//   FrontPorch   front-porch length in lines (F)
//   ActiveVideo  active-video length in lines (A)
//   BackPorch    back-porch length in lines (B)
//   vsync        vertical sync, low while the line counter is inside the pulse
//   yposition    row index inside active video, 0 elsewhere
//   FrameEnd     (only with FRAME_END_EN) one-clock pulse on the T-1 -> 0 wrap
//
// Optional feature macro: FRAME_END_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vsync_module_2018fall_template #(
    parameter int unsigned CNT_W = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       LineEnd,
    input  logic [9:0] SynchPulse,
    input  logic [9:0] FrontPorch,
    input  logic [9:0] ActiveVideo,
    input  logic [9:0] BackPorch,
    output logic       vsync,
`ifdef FRAME_END_EN
    output logic       FrameEnd,
`endif
    output logic [9:0] yposition
);

    logic             le_d_q;
    logic             le_d_d;
    logic [CNT_W-1:0] line_q;
    logic [CNT_W-1:0] line_d;

    logic [CNT_W-1:0] s_len;
    logic [CNT_W-1:0] sb_len;
    logic [CNT_W-1:0] sba_len;
    logic [CNT_W-1:0] total;
    logic             tick;
    logic             wrap;
    logic             in_active;

`ifdef FRAME_END_EN
    logic             frame_end_q;
    logic             frame_end_d;
`endif

    // Region boundaries as running sums; CNT_W holds four 10-bit lengths.
    always_comb begin
        s_len   = CNT_W'(SynchPulse);
        sb_len  = s_len + CNT_W'(BackPorch);
        sba_len = sb_len + CNT_W'(ActiveVideo);
        total   = sba_len + CNT_W'(FrontPorch);
    end

    // Line counter next state. A zero-length frame always wraps, pinning L at 0;
    // >= (not ==) lets the counter recover when the lengths shrink mid-frame.
    always_comb begin
        le_d_d = LineEnd;
        tick   = LineEnd & ~le_d_q;
        wrap   = (total == '0) || (line_q >= total - CNT_W'(1));
        line_d = line_q;
        if (tick) begin
            line_d = wrap ? '0 : line_q + CNT_W'(1);
        end
    end

`ifdef FRAME_END_EN
    always_comb begin
        frame_end_d = tick & wrap & (total != '0);
    end
`endif

    // Output decode straight from the registered counter.
    always_comb begin
        vsync     = (line_q < s_len) ? 1'b0 : 1'b1;
        in_active = (line_q >= sb_len) && (line_q < sba_len);
        yposition = in_active ? 10'(line_q - sb_len) : 10'd0;
    end

    // le_d resets high so a LineEnd already asserted at reset release is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            le_d_q <= 1'b1;
            line_q <= '0;
        end else begin
            le_d_q <= le_d_d;
            line_q <= line_d;
        end
    end

`ifdef FRAME_END_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= frame_end_d;
        end
    end

    assign FrameEnd = frame_end_q;
`endif

endmodule

// File: tb/tb_vsync_module_2018fall_template.sv
`timescale 1ns/1ps

module tb_vsync_module_2018fall_template;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       LineEnd = 1'b0;
    logic [9:0] sp = 10'd2;
    logic [9:0] fp = 10'd2;
    logic [9:0] av = 10'd5;
    logic [9:0] bp = 10'd3;
    logic       vsync;
    logic [9:0] yposition;
`ifdef FRAME_END_EN
    logic       FrameEnd;
`endif

    int errors = 0;
    int checks = 0;

    vsync_module_2018fall_template dut (
        .clock       (clock),
        .reset       (reset),
        .LineEnd     (LineEnd),
        .SynchPulse  (sp),
        .FrontPorch  (fp),
        .ActiveVideo (av),
        .BackPorch   (bp),
        .vsync       (vsync),
`ifdef FRAME_END_EN
        .FrameEnd    (FrameEnd),
`endif
        .yposition   (yposition)
    );

    always #1 clock = ~clock;

    // Behavioural model: integer line number plus last-seen LineEnd level.
    int m_line;
    bit m_le;
    bit m_fe;
    bit m_tk;

    function automatic int tot();
        return int'(sp) + int'(bp) + int'(av) + int'(fp);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_line = 0;
            m_le   = 1'b1;
            m_fe   = 1'b0;
        end else begin
            m_tk = LineEnd && !m_le;
            m_le = LineEnd;
            m_fe = 1'b0;
            if (m_tk) begin
                if (m_line >= tot() - 1) begin
                    m_fe   = (tot() != 0);
                    m_line = 0;
                end else begin
                    m_line = m_line + 1;
                end
            end
        end
    end

    function automatic logic exp_vs();
        return (m_line < int'(sp)) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [9:0] exp_yp();
        int sb;
        sb = int'(sp) + int'(bp);
        if (m_line >= sb && m_line < sb + int'(av)) return 10'(m_line - sb);
        return 10'd0;
    endfunction

    // Advance one clock; sample point is 0.5 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #0.5;
    endtask

    task automatic do_reset();
        LineEnd = 1'b0;
        reset   = 1'b0;
        step();
        reset   = 1'b1;
        step();
    endtask

    task automatic test_reset();
        sp = 10'd2; bp = 10'd3; av = 10'd5; fp = 10'd2;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            LineEnd = ~LineEnd;
            step();
            checks++;
            if (vsync !== 1'b0 || yposition !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold i=%0d got vsync=%b ypos=%0d exp vsync=0 ypos=0", i, vsync, yposition);
            end
        end
        LineEnd = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (vsync !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got vsync=%b exp 0", vsync);
        end
        // two rising edges -> line 2 (back porch)
        for (int i = 0; i < 2; i++) begin
            LineEnd = 1'b1; step();
            LineEnd = 1'b0; step();
        end
        checks++;
        if (vsync !== 1'b1 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL reset_first_count got vsync=%b ypos=%0d exp vsync=1 ypos=0", vsync, yposition);
        end
        // four more -> line 6, row 1
        for (int i = 0; i < 4; i++) begin
            LineEnd = 1'b1; step();
            LineEnd = 1'b0; step();
        end
        checks++;
        if (yposition !== 10'd1) begin
            errors++;
            $display("FAIL reset_pre_mid got ypos=%0d exp 1", yposition);
        end
        // asynchronous reset between clock edges
        #0.3;
        reset = 1'b0;
        #0.2;
        checks++;
        if (vsync !== 1'b0 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL reset_async got vsync=%b ypos=%0d exp vsync=0 ypos=0", vsync, yposition);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_frame();
        int vs_tab [12];
        int yp_tab [12];
        vs_tab = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        yp_tab = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0};
        sp = 10'd2; bp = 10'd3; av = 10'd5; fp = 10'd2;
        do_reset();
        checks++;
        if (vsync !== 1'b0 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL frame_start got vsync=%b ypos=%0d exp vsync=0 ypos=0", vsync, yposition);
        end
        // LineEnd toggles every 6 ns: 3 clocks high, 3 clocks low
        for (int k = 1; k <= 24; k++) begin
            LineEnd = 1'b1;
            for (int c = 0; c < 6; c++) begin
                if (c == 3) LineEnd = 1'b0;
                step();
                checks++;
                if (vsync !== 1'(vs_tab[k % 12]) || yposition !== 10'(yp_tab[k % 12])) begin
                    errors++;
                    $display("FAIL frame_line line=%0d got vsync=%b ypos=%0d exp vsync=%0d ypos=%0d",
                             k % 12, vsync, yposition, vs_tab[k % 12], yp_tab[k % 12]);
                end
            end
        end
    endtask

    task automatic test_level();
        sp = 10'd1; bp = 10'd0; av = 10'd8; fp = 10'd0;
        do_reset();
        LineEnd = 1'b1;
        repeat (10) step();
        checks++;
        if (vsync !== 1'b1 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL level_hold got vsync=%b ypos=%0d exp vsync=1 ypos=0", vsync, yposition);
        end
        LineEnd = 1'b0; step();
        LineEnd = 1'b1; step();
        checks++;
        if (yposition !== 10'd1) begin
            errors++;
            $display("FAIL level_second got ypos=%0d exp 1", yposition);
        end
        // LineEnd already high when reset releases
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (5) step();
        checks++;
        if (vsync !== 1'b0) begin
            errors++;
            $display("FAIL level_at_release got vsync=%b exp 0", vsync);
        end
        LineEnd = 1'b0; step();
        LineEnd = 1'b1; step();
        checks++;
        if (vsync !== 1'b1) begin
            errors++;
            $display("FAIL level_after_release got vsync=%b exp 1", vsync);
        end
        LineEnd = 1'b0; step();
    endtask

    task automatic test_shrink();
        sp = 10'd2; bp = 10'd3; av = 10'd5; fp = 10'd2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            LineEnd = 1'b1; step();
            LineEnd = 1'b0; step();
        end
        checks++;
        if (vsync !== 1'b1 || yposition !== 10'd4) begin
            errors++;
            $display("FAIL shrink_line9 got vsync=%b ypos=%0d exp vsync=1 ypos=4", vsync, yposition);
        end
        av = 10'd2;
        #0.1;
        checks++;
        if (vsync !== 1'b1 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL shrink_redecode got vsync=%b ypos=%0d exp vsync=1 ypos=0", vsync, yposition);
        end
        LineEnd = 1'b1; step();
        checks++;
        if (vsync !== 1'b0 || yposition !== 10'd0) begin
            errors++;
            $display("FAIL shrink_wrap got vsync=%b ypos=%0d exp vsync=0 ypos=0", vsync, yposition);
        end
        LineEnd = 1'b0; step();
    endtask

    task automatic test_degenerate();
        sp = 10'd0; bp = 10'd3; av = 10'd4; fp = 10'd2;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            LineEnd = 1'b1; step();
            checks++;
            if (vsync !== 1'b1) begin
                errors++;
                $display("FAIL degen_s0 i=%0d got vsync=%b exp 1", i, vsync);
            end
            LineEnd = 1'b0; step();
        end
        sp = 10'd0; bp = 10'd0; av = 10'd0; fp = 10'd0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            LineEnd = 1'b1; step();
            LineEnd = 1'b0; step();
            checks++;
            if (yposition !== 10'd0 || vsync !== 1'b1) begin
                errors++;
                $display("FAIL degen_zero i=%0d got vsync=%b ypos=%0d exp vsync=1 ypos=0", i, vsync, yposition);
            end
        end
        // counter must still be 0: a 1-line pulse decodes as sync immediately
        sp = 10'd1;
        #0.1;
        checks++;
        if (vsync !== 1'b0) begin
            errors++;
            $display("FAIL degen_zero_line got vsync=%b exp 0", vsync);
        end
    endtask

    task automatic test_random();
        sp = 10'd2; bp = 10'd3; av = 10'd5; fp = 10'd2;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 47 == 0) begin
                sp = 10'($urandom_range(0, 6));
                bp = 10'($urandom_range(0, 6));
                av = 10'($urandom_range(0, 9));
                fp = 10'($urandom_range(0, 6));
            end
            if (i % 211 == 100) reset = 1'b0;
            else reset = 1'b1;
            LineEnd = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (vsync !== exp_vs() || yposition !== exp_yp()) begin
                errors++;
                $display("FAIL random i=%0d line=%0d got vsync=%b ypos=%0d exp vsync=%b ypos=%0d",
                         i, m_line, vsync, yposition, exp_vs(), exp_yp());
            end
`ifdef FRAME_END_EN
            checks++;
            if (FrameEnd !== m_fe) begin
                errors++;
                $display("FAIL random_frame_end i=%0d got %b exp %b", i, FrameEnd, m_fe);
            end
`endif
        end
        reset = 1'b1;
        LineEnd = 1'b0;
        step();
    endtask

`ifdef FRAME_END_EN
    task automatic test_frame_end();
        int pulses;
        pulses = 0;
        sp = 10'd2; bp = 10'd3; av = 10'd5; fp = 10'd2;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            LineEnd = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (c == 2) LineEnd = 1'b0;
                step();
                if (FrameEnd === 1'b1) pulses++;
                checks++;
                if (FrameEnd !== ((c == 0 && k % 12 == 0) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL frame_end k=%0d c=%0d got %b", k, c, FrameEnd);
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL frame_end_count got %0d exp 3", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_level();
        test_shrink();
        test_degenerate();
        test_random();
`ifdef FRAME_END_EN
        test_frame_end();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vsync_module_2018fall_template.md
Name: vsync_module_2018fall_template

Overview:
Vertical-sync generator for the VGA Pong display path. It counts horizontal line-end events from the hsync block and walks a programmable frame: sync pulse, back porch, active video, front porch. It drives the vsync pin and the current active-video row (yposition) consumed by the pixel/game logic. Timing lengths are run-time inputs, not parameters.

Parameters:
CNT_W, 12, internal line-counter width; must hold the sum of four 10-bit lengths (max 4092).

Ports:
clock  input  1   system clock; all state on rising edge
reset  input  1   asynchronous, active-low reset (0 = reset asserted)
LineEnd  input  1   line-end strobe/level from hsync block, synchronous to clock
SynchPulse  input  10  vsync pulse length, in lines
FrontPorch  input  10  front-porch length, in lines
ActiveVideo  input  10  active-video length, in lines
BackPorch  input  10  back-porch length, in lines
vsync  output  1   vertical sync, active-low during sync pulse
yposition  output  10  row index inside active video, 0 outside it

Behaviour:
- Edge detect: register LineEnd into le_d; line tick = LineEnd & ~le_d. A LineEnd held high for several clocks advances the counter exactly once.
- le_d resets to 1, so a LineEnd already high at reset release is not counted.
- Frame order: sync [0, S), back porch [S, S+B), active [S+B, S+B+A), front porch [S+B+A, T). Here S = SynchPulse, B = BackPorch, A = ActiveVideo, F = FrontPorch, T = S+B+A+F, all computed at CNT_W bits with no overflow.
- Counter L (CNT_W bits) resets to 0.
- On a tick: if L >= T-1, L <= 0; otherwise L <= L+1. The >= comparison ensures recovery if the lengths shrink mid-frame.
- If T == 0, L stays at 0.
- Outputs are combinational decodes of the registered L, so they change in the same cycle L updates. There is no extra latency beyond the one-clock edge-detect register.
- vsync = 0 when L < S, else 1. With S == 0, vsync is constantly 1.
- yposition = L-(S+B), truncated to 10 bits, when S+B <= L < S+B+A; otherwise 0. With A == 0, yposition is always 0.
- Reset values:
  - L = 0
  - vsync = 0 (if S > 0), else 1
  - yposition = 0 (if S+B > 0 or A == 0)
- Reset asserted mid-frame: immediate return to L = 0 regardless of clock.
- Timing inputs are sampled continuously. Changing them mid-frame re-decodes the outputs immediately, with no glitch filtering.

Optional Feature:
- FRAME_END_EN defined: adds output port FrameEnd (1 bit), high for exactly one clock on the tick where L wraps from T-1 to 0. FrameEnd resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with LineEnd toggling -> L stays 0, vsync=0, yposition=0. Release -> counting starts on the next LineEnd rising edge.
- S=2, B=3, A=5, F=2 (T=12); LineEnd toggling every 6 ns, clock period 2 ns:
  - lines 0-1: vsync=0, yposition=0
  - lines 2-4: vsync=1, yposition=0
  - lines 5-9: yposition=0,1,2,3,4
  - lines 10-11: yposition=0
  - line 12 wraps to 0 and vsync=0 again
- Level vs edge: LineEnd held high 10 clocks -> L advances by exactly 1. LineEnd high at reset release -> no count.
- Mid-frame shrink: at L=9, change A to 2 (T=9) -> next tick wraps L to 0.
- Degenerate: S=0 -> vsync constantly 1. All lengths 0 -> L, yposition stay 0.
- FRAME_END_EN: with T=12, FrameEnd pulses one clock every 12 line ticks, coincident with the 11->0 wrap.
